// File: rtl/sd_pkg.sv
// Shared definitions for the SD register-port arbiter.
//   SD_ADDR_W   : SD controller register address width
//   SD_DATA_W   : SD controller register data width
//   arb_state_t : arbiter FSM states
package sd_pkg;

    localparam int SD_ADDR_W = 7;
    localparam int SD_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE,
        HOLD
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating find-first for round-robin arbitration.
// Ports:
//   req_i     : request vector, one bit per requester
//   rr_last_i : index of the most recently served requester
//   win_o     : one-hot winner, first set req_i bit scanning from rr_last_i+1 (mod NREQ)
//   found_o   : at least one request present
module rr_pick #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDXW = 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDXW-1:0] rr_last_i,
    output logic [NREQ-1:0] win_o,
    output logic            found_o
);

    logic [IDXW-1:0] idx;

    always_comb begin
        win_o   = '0;
        found_o = 1'b0;
        idx     = '0;
        // k starts at 1 so the last winner is scanned last.
        for (int k = 1; k <= int'(NREQ); k++) begin
            idx = IDXW'((int'(rr_last_i) + k) % int'(NREQ));
            if (!found_o && req_i[idx]) begin
                win_o[idx] = 1'b1;
                found_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sd_reg_arbiter.sv
// Round-robin arbiter sharing the SD controller register port between NREQ requesters.
// One register transaction per grant; a requester may hold req_lock to keep ownership
// across a multi-register sequence, bounded by LOCK_TIMEOUT idle cycles.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   req/req_we/req_lock   : per-requester request, write flag, keep-ownership flag
//   req_addr/req_wdata    : packed per-requester address (7b each) and write data (8b each)
//   gnt                   : one-hot current owner
//   ack                   : one-cycle completion pulse to the owner
//   rdata                 : read data, valid while ack is high
//   lock_err              : one-cycle pulse when a lock is forcibly released
//   sd_addr/sd_we/sd_data_o : SD register port towards the core
//   sd_data_i             : SD read data, combinational from sd_addr
module sd_reg_arbiter
    import sd_pkg::*;
#(
    parameter int unsigned NREQ         = 2,
    parameter int unsigned LOCK_TIMEOUT = 256
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NREQ-1:0]             req,
    input  logic [NREQ-1:0]             req_we,
    input  logic [NREQ-1:0]             req_lock,
    input  logic [NREQ*SD_ADDR_W-1:0]   req_addr,
    input  logic [NREQ*SD_DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]             gnt,
    output logic [NREQ-1:0]             ack,
    output logic [SD_DATA_W-1:0]        rdata,
    output logic                        lock_err,
    output logic [SD_ADDR_W-1:0]        sd_addr,
    output logic                        sd_we,
    output logic [SD_DATA_W-1:0]        sd_data_o,
    input  logic [SD_DATA_W-1:0]        sd_data_i
);

    localparam int unsigned IdxW = $clog2(NREQ);
    localparam int unsigned CntW = $clog2(LOCK_TIMEOUT + 1);
    // Timeout is detected on the incremented value so lock_err lands LOCK_TIMEOUT cycles
    // after the ack that entered HOLD. Requires LOCK_TIMEOUT >= 2.
    localparam logic [CntW-1:0] CntLast = CntW'(LOCK_TIMEOUT - 1);

    arb_state_t           state_q;
    logic [NREQ-1:0]      gnt_q, ack_q;
    logic [IdxW-1:0]      owner_q, rr_last_q;
    logic [CntW-1:0]      cnt_q, cnt_inc;
    logic                 lock_err_q, sd_we_q;
    logic [SD_ADDR_W-1:0] sd_addr_q;
    logic [SD_DATA_W-1:0] sd_wdata_q, rdata_q;

    logic [NREQ-1:0]      win_oh, cap_oh;
    logic                 win_found, start_txn, cap_we;
    logic [IdxW-1:0]      win_idx, cap_idx;
    logic [SD_ADDR_W-1:0] cap_addr;
    logic [SD_DATA_W-1:0] cap_wdata;

    rr_pick #(
        .NREQ (NREQ),
        .IDXW (IdxW)
    ) u_rr_pick (
        .req_i     (req),
        .rr_last_i (rr_last_q),
        .win_o     (win_oh),
        .found_o   (win_found)
    );

    // Capture source: the round-robin winner in IDLE, the locked owner in HOLD.
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (win_oh[i]) win_idx = IdxW'(i);
        end
        cap_idx   = (state_q == HOLD) ? owner_q : win_idx;
        cap_oh    = (state_q == HOLD) ? gnt_q : win_oh;
        cap_we    = req_we[cap_idx];
        cap_addr  = '0;
        cap_wdata = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (cap_idx == IdxW'(i)) begin
                cap_addr  = req_addr[i*SD_ADDR_W +: SD_ADDR_W];
                cap_wdata = req_wdata[i*SD_DATA_W +: SD_DATA_W];
            end
        end
        start_txn = ((state_q == IDLE) && win_found) || ((state_q == HOLD) && req[owner_q]);
        cnt_inc   = cnt_q + CntW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            ack_q      <= '0;
            lock_err_q <= 1'b0;
            sd_we_q    <= 1'b0;
            sd_addr_q  <= '0;
            sd_wdata_q <= '0;
            rdata_q    <= '0;
            owner_q    <= '0;
            rr_last_q  <= IdxW'(NREQ - 1);
            cnt_q      <= '0;
        end else begin
            ack_q      <= '0;
            lock_err_q <= 1'b0;
            sd_we_q    <= 1'b0;
            if (start_txn) begin
                owner_q    <= cap_idx;
                gnt_q      <= cap_oh;
                sd_addr_q  <= cap_addr;
                sd_wdata_q <= cap_wdata;
                sd_we_q    <= cap_we;
                state_q    <= ACCESS;
            end else begin
                unique case (state_q)
                    IDLE: state_q <= IDLE;
                    ACCESS: begin
                        // sd_we_q still holds this transaction's op during ACCESS.
                        if (!sd_we_q) rdata_q <= sd_data_i;
                        ack_q   <= gnt_q;
                        state_q <= DONE;
                    end
                    DONE: begin
                        rr_last_q <= owner_q;
                        if (req_lock[owner_q]) begin
                            cnt_q   <= '0;
                            state_q <= HOLD;
                        end else begin
                            gnt_q   <= '0;
                            state_q <= IDLE;
                        end
                    end
                    HOLD: begin
                        if (!req_lock[owner_q]) begin
                            gnt_q   <= '0;
                            state_q <= IDLE;
                        end else if (cnt_inc == CntLast) begin
                            lock_err_q <= 1'b1;
                            gnt_q      <= '0;
                            state_q    <= IDLE;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign gnt       = gnt_q;
    assign ack       = ack_q;
    assign rdata     = rdata_q;
    assign lock_err  = lock_err_q;
    assign sd_addr   = sd_addr_q;
    assign sd_we     = sd_we_q;
    assign sd_data_o = sd_wdata_q;

endmodule

// File: tb/tb_sd_reg_arbiter.sv
// Self-checking bench for sd_reg_arbiter: directed vectors, multi-cycle corner sequences and
// randomized requesters, all compared every cycle against a transaction-timeline model.
module tb_sd_reg_arbiter;

    localparam int NREQ = 2;
    localparam int LT   = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req, req_we, req_lock;
    logic [NREQ*7-1:0] req_addr;
    logic [NREQ*8-1:0] req_wdata;
    logic [NREQ-1:0]   gnt, ack;
    logic [7:0]        rdata, sd_data_o, sd_data_i;
    logic              lock_err, sd_we;
    logic [6:0]        sd_addr;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // SD register file stand-in: fixed contents, 0x3C at address 0x12.
    function automatic logic [7:0] sd_fn(input logic [6:0] a);
        if (a == 7'h12) return 8'h3C;
        return ({1'b0, a} * 8'd37) + 8'd11;
    endfunction

    assign sd_data_i = sd_fn(sd_addr);

    always #5 clk = ~clk;

    sd_reg_arbiter #(
        .NREQ         (NREQ),
        .LOCK_TIMEOUT (LT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_we    (req_we),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .ack       (ack),
        .rdata     (rdata),
        .lock_err  (lock_err),
        .sd_addr   (sd_addr),
        .sd_we     (sd_we),
        .sd_data_o (sd_data_o),
        .sd_data_i (sd_data_i)
    );

    // ---------------- reference model (transaction timeline) ----------------
    logic [NREQ-1:0] m_gnt, m_ack, seen_ack;
    logic            m_we, m_lerr, m_rvalid;
    logic [6:0]      m_addr;
    logic [7:0]      m_wdata, m_rdata;
    int              mcyc, rr_last, t_start, t_who, lock_owner, lock_since;
    bit              t_active, t_we;

    task automatic model_reset();
        m_gnt = '0; m_ack = '0; m_we = 1'b0; m_lerr = 1'b0; m_rvalid = 1'b0;
        m_addr = '0; m_wdata = '0; m_rdata = '0;
        rr_last = NREQ - 1; t_active = 0; lock_owner = -1;
    endtask

    task automatic start_txn(input int w);
        t_active   = 1;
        t_start    = mcyc;
        t_who      = w;
        t_we       = req_we[w];
        lock_owner = -1;
        m_gnt      = '0;
        m_gnt[w]   = 1'b1;
        m_we       = t_we;
        m_addr     = req_addr[w*7 +: 7];
        m_wdata    = req_wdata[w*8 +: 8];
    endtask

    // Called with the inputs the DUT samples at the coming edge; yields next-cycle outputs.
    task automatic model_step();
        if (!rst_n) begin
            model_reset();
        end else begin
            m_ack = '0; m_we = 1'b0; m_lerr = 1'b0; m_rvalid = 1'b0;
            if (t_active && mcyc - t_start == 1) begin
                m_ack[t_who] = 1'b1;
                if (!t_we) begin
                    m_rdata  = sd_fn(m_addr);
                    m_rvalid = 1'b1;
                end
            end else if (t_active && mcyc - t_start == 2) begin
                t_active = 0;
                rr_last  = t_who;
                if (req_lock[t_who]) begin
                    lock_owner = t_who;
                    lock_since = mcyc;
                end else begin
                    m_gnt = '0;
                end
            end else if (lock_owner >= 0) begin
                if (req[lock_owner]) begin
                    start_txn(lock_owner);
                end else if (!req_lock[lock_owner]) begin
                    lock_owner = -1;
                    m_gnt      = '0;
                end else if (mcyc - lock_since == LT - 1) begin
                    m_lerr     = 1'b1;
                    lock_owner = -1;
                    m_gnt      = '0;
                end
            end else begin
                for (int k = 1; k <= NREQ; k++) begin
                    int i;
                    i = (rr_last + k) % NREQ;
                    if (req[i]) begin
                        start_txn(i);
                        break;
                    end
                end
            end
        end
        mcyc++;
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic compare_all();
        chk("gnt", 32'(gnt), 32'(m_gnt));
        chk("ack", 32'(ack), 32'(m_ack));
        chk("sd_we", 32'(sd_we), 32'(m_we));
        chk("sd_addr", 32'(sd_addr), 32'(m_addr));
        chk("sd_data_o", 32'(sd_data_o), 32'(m_wdata));
        chk("lock_err", 32'(lock_err), 32'(m_lerr));
        if (m_rvalid) chk("rdata", 32'(rdata), 32'(m_rdata));
        chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
        chk("ack_within_gnt", 32'(|(ack & ~gnt)), 32'd0);
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
        seen_ack = m_ack;
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_ack(input int w, input string name);
        bit seen;
        seen = 0;
        for (int t = 0; t < 12; t++) begin
            tick();
            if (ack[w]) begin
                seen = 1;
                break;
            end
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    task automatic new_fields(input int i);
        req_we[i]          = 1'($urandom_range(0, 1));
        req_addr[i*7 +: 7] = 7'($urandom);
        req_wdata[i*8 +: 8] = 8'($urandom);
        if ($urandom_range(0, 3) == 0) req_lock[i] = ~req_lock[i];
    endtask

    // ---------------- stimulus ----------------
    typedef struct {
        int         who;
        logic       we;
        logic [6:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t            vecs[6];
    logic [NREQ-1:0] oh;
    int              order[$];
    int              acks0, t0;
    bit              early1, got;

    initial begin
        vecs[0] = '{who: 0, we: 1'b1, addr: 7'h05, wdata: 8'hA5, exp_rdata: 8'h00};
        vecs[1] = '{who: 1, we: 1'b0, addr: 7'h12, wdata: 8'h00, exp_rdata: 8'h3C};
        vecs[2] = '{who: 0, we: 1'b0, addr: 7'h12, wdata: 8'h77, exp_rdata: 8'h3C};
        vecs[3] = '{who: 1, we: 1'b1, addr: 7'h7F, wdata: 8'hFF, exp_rdata: 8'h00};
        vecs[4] = '{who: 0, we: 1'b0, addr: 7'h00, wdata: 8'h00, exp_rdata: 8'h0B};
        vecs[5] = '{who: 1, we: 1'b0, addr: 7'h7F, wdata: 8'h5A, exp_rdata: 8'h66};

        req = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
        seen_ack = '0; mcyc = 0;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        tick();
        chk("reset_gnt", 32'(gnt), 32'd0);
        chk("reset_sd_we", 32'(sd_we), 32'd0);
        chk("reset_rdata", 32'(rdata), 32'd0);
        chk("reset_sd_addr", 32'(sd_addr), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single transactions: sd_we/addr/data at N+1, ack and rdata at N+2.
        for (int v = 0; v < 6; v++) begin
            oh = '0;
            oh[vecs[v].who] = 1'b1;
            req[vecs[v].who] = 1'b1;
            req_we[vecs[v].who] = vecs[v].we;
            req_addr[vecs[v].who*7 +: 7] = vecs[v].addr;
            req_wdata[vecs[v].who*8 +: 8] = vecs[v].wdata;
            tick();
            chk("vec_gnt", 32'(gnt), 32'(oh));
            chk("vec_sd_we", 32'(sd_we), 32'(vecs[v].we));
            chk("vec_sd_addr", 32'(sd_addr), 32'(vecs[v].addr));
            if (vecs[v].we) chk("vec_sd_data", 32'(sd_data_o), 32'(vecs[v].wdata));
            tick();
            chk("vec_ack", 32'(ack), 32'(oh));
            chk("vec_we_one_cycle", 32'(sd_we), 32'd0);
            if (!vecs[v].we) chk("vec_rdata", 32'(rdata), 32'(vecs[v].exp_rdata));
            req = '0;
            tick();
        end

        // Contention: both held high, last winner was 1 so order is 0,1,0,1.
        req_we = '1;
        req_addr = {7'h21, 7'h20};
        req_wdata = {8'h11, 8'h10};
        req = '1;
        for (int t = 0; t < 30 && order.size() < 4; t++) begin
            tick();
            if (ack == 2'b01) order.push_back(0);
            else if (ack == 2'b10) order.push_back(1);
            else if (ack != 2'b00) order.push_back(9);
        end
        chk("contention_count", 32'(order.size()), 32'd4);
        foreach (order[i]) chk("contention_order", 32'(order[i]), 32'(i % 2));
        req = '0;
        tick();
        tick();

        // Lock: requester 0 issues three writes back-to-back while 1 waits.
        req_lock[0] = 1'b1;
        req_addr[6:0] = 7'h30;
        req_wdata[7:0] = 8'h01;
        req = '1;
        acks0 = 0;
        early1 = 0;
        for (int t = 0; t < 40 && acks0 < 3; t++) begin
            tick();
            if (gnt[1]) early1 = 1;
            if (ack[0]) begin
                acks0++;
                req_wdata[7:0] = 8'(acks0 + 1);
            end
        end
        chk("lock_acks", 32'(acks0), 32'd3);
        chk("lock_no_early_gnt1", 32'(early1), 32'd0);
        req[0] = 1'b0;
        req_lock[0] = 1'b0;
        got = 0;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (gnt[1]) begin
                got = 1;
                break;
            end
        end
        chk("lock_gnt1_after_release", 32'(got), 32'd1);
        wait_ack(1, "lock_req1_ack");
        req = '0;
        tick();
        tick();

        // Timeout: requester 0 keeps lock but goes idle; 1 is pending.
        req_lock[0] = 1'b1;
        req[0] = 1'b1;
        wait_ack(0, "timeout_first_ack");
        t0 = cyc;
        req[0] = 1'b0;
        req[1] = 1'b1;
        got = 0;
        for (int t = 0; t < 3 * LT; t++) begin
            tick();
            if (lock_err) begin
                got = 1;
                break;
            end
        end
        chk("timeout_lock_err", 32'(got), 32'd1);
        chk("timeout_delay", 32'(cyc - t0), 32'(LT));
        req_lock[0] = 1'b0;
        tick();
        chk("timeout_next_gnt", 32'(gnt), 32'b10);
        wait_ack(1, "timeout_req1_ack");
        req = '0;
        tick();
        tick();

        // Reset in ACCESS: requester 0 served last, then 1 starts a write and reset hits.
        req[0] = 1'b1;
        wait_ack(0, "rst_prep_ack");
        req[0] = 1'b0;
        tick();
        req[1] = 1'b1;
        req_addr[13:7] = 7'h44;
        req_wdata[15:8] = 8'h99;
        tick();
        chk("rst_pre_sd_we", 32'(sd_we), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_sd_we", 32'(sd_we), 32'd0);
        chk("rst_sd_addr", 32'(sd_addr), 32'd0);
        chk("rst_sd_data", 32'(sd_data_o), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        req = '1;
        tick();
        chk("rst_hold_sd_we", 32'(sd_we), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_first_gnt", 32'(gnt), 32'b01);
        req = '0;
        for (int t = 0; t < 4; t++) tick();

        // Random requesters obeying the handshake; model compares every cycle.
        req_lock = '0;
        for (int t = 0; t < 1500; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && seen_ack[i]) begin
                    if ($urandom_range(0, 3) == 0) new_fields(i);
                    else req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 7) == 0) begin
                    new_fields(i);
                    req[i] = 1'b1;
                end
                if (!req[i] && $urandom_range(0, 39) == 0) req_lock[i] = ~req_lock[i];
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
